// File: rtl/debug_capture_pkg.sv
// Shared types for the debug capture FIFO: capture modes, FSM states and
// the raw-mode decoder used at arm/reset time.
package debug_capture_pkg;

    typedef enum logic [1:0] {
        MODE_STOP = 2'd0,
        MODE_RING = 2'd1,
        MODE_TRIG = 2'd2
    } mode_e;

    typedef enum logic [1:0] {
        ST_ARMED   = 2'd0,
        ST_RUN     = 2'd1,
        ST_STOPPED = 2'd2
    } state_e;

    // Encoding 3 is reserved and behaves as stop-when-full.
    function automatic mode_e decode_mode(input logic [1:0] raw);
        case (raw)
            2'd1:    return MODE_RING;
            2'd2:    return MODE_TRIG;
            default: return MODE_STOP;
        endcase
    endfunction

endpackage

// File: rtl/capture_edge_sync.sv
// Brings the asynchronous capture strobe into i_clk and emits a registered
// one-cycle pulse per rising edge.
module capture_edge_sync (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_async,
    output logic o_pulse
);

    logic r_sync1;
    logic r_sync2;
    logic r_prev;
    logic r_pulse;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_sync1 <= i_async;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            r_pulse <= r_sync2 & ~r_prev;
        end
    end

    assign o_pulse = r_pulse;

endmodule

// File: rtl/debug_capture_fifo.sv
// Debug instruction trace buffer: samples i_data on each synchronised capture
// strobe into a DEPTH-entry FIFO under stop, ring or trigger capture modes.
module debug_capture_fifo
    import debug_capture_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_capture,
    input  logic [1:0]        i_mode,
    input  logic [DATA_W-1:0] i_trig_value,
    input  logic              i_arm,
    input  logic              i_rd_en,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_rd_valid,
    output logic [DATA_W-1:0] o_last,
    output logic [CNT_W-1:0]  o_count,
    output logic              o_empty,
    output logic              o_full,
    output logic              o_overflow,
    output logic              o_triggered
);

    localparam int                PTR_W    = $clog2(DEPTH);
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);

    mode_e              r_mode;
    state_e             r_state;
    state_e             w_state_next;
    logic               r_started;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic [DATA_W-1:0]  r_mem [DEPTH];
    logic [DATA_W-1:0]  r_rd_data;
    logic [DATA_W-1:0]  r_last;
    logic               r_rd_valid;
    logic               r_overflow;
    logic               r_triggered;

    logic               w_cap;
    logic               w_arm_now;
    logic               w_full;
    logic               w_pop;
    logic               w_push;
    logic               w_set_trig;
    logic               w_drop;
    logic               w_overwrite;
    logic               w_write;
    logic [CNT_W-1:0]   w_count_next;

    capture_edge_sync u_capture_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_async (i_capture),
        .o_pulse (w_cap)
    );

    // First clock after reset release behaves like an arm: mode gets latched.
    assign w_arm_now   = !r_started || i_arm;
    assign w_full      = (r_count == FULL_CNT);
    assign w_pop       = !w_arm_now && i_rd_en && (r_count != '0);
    assign w_drop      = w_push && w_full && !w_pop && (r_mode != MODE_RING);
    assign w_overwrite = w_push && w_full && !w_pop && (r_mode == MODE_RING);
    assign w_write     = w_push && !w_drop;

    always_comb begin
        w_count_next = r_count;
        if (w_write && !w_overwrite) w_count_next = w_count_next + CNT_W'(1);
        if (w_pop)                   w_count_next = w_count_next - CNT_W'(1);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= ST_RUN;
        else          r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        if (w_arm_now) begin
            w_state_next = (decode_mode(i_mode) == MODE_TRIG) ? ST_ARMED : ST_RUN;
        end else begin
            case (r_state)
                ST_ARMED: if (w_set_trig) w_state_next = ST_RUN;
                ST_RUN:   if (r_mode == MODE_TRIG && w_write && w_count_next == FULL_CNT)
                              w_state_next = ST_STOPPED;
                default:  w_state_next = r_state;
            endcase
        end
    end

    always_comb begin
        w_push     = 1'b0;
        w_set_trig = 1'b0;
        if (!w_arm_now) begin
            case (r_state)
                ST_ARMED: begin
                    w_push     = w_cap && (i_data == i_trig_value);
                    w_set_trig = w_push;
                end
                ST_RUN:   w_push = w_cap;
                default:  w_push = 1'b0;
            endcase
        end
    end

    // Storage carries no reset so it can map onto block or distributed RAM.
    always_ff @(posedge i_clk) begin
        if (w_write) r_mem[r_wr_ptr] <= i_data;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mode      <= MODE_STOP;
            r_started   <= 1'b0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_rd_data   <= '0;
            r_last      <= '0;
            r_rd_valid  <= 1'b0;
            r_overflow  <= 1'b0;
            r_triggered <= 1'b0;
        end else begin
            r_rd_valid <= w_pop;
            if (w_pop) r_rd_data <= r_mem[r_rd_ptr];
            if (w_arm_now) begin
                r_mode      <= decode_mode(i_mode);
                r_started   <= 1'b1;
                r_wr_ptr    <= '0;
                r_rd_ptr    <= '0;
                r_count     <= '0;
                r_overflow  <= 1'b0;
                r_triggered <= 1'b0;
            end else begin
                if (w_write) begin
                    r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                    r_last   <= i_data;
                end
                // A ring overwrite discards the oldest entry along with the read.
                if (w_pop || w_overwrite) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                r_count <= w_count_next;
                if (w_drop || w_overwrite) r_overflow  <= 1'b1;
                if (w_set_trig)            r_triggered <= 1'b1;
            end
        end
    end

    assign o_rd_data   = r_rd_data;
    assign o_rd_valid  = r_rd_valid;
    assign o_last      = r_last;
    assign o_count     = r_count;
    assign o_empty     = (r_count == '0);
    assign o_full      = w_full;
    assign o_overflow  = r_overflow;
    assign o_triggered = r_triggered;

endmodule
